// File: rtl/audio_playback_ctrl.sv
// Playback sequencer: walks the sample ROM, feeds every sample to the FIR,
// hands raw or filtered samples to the CODEC DAC port and drains the ADC FIFO.
module audio_playback_ctrl #(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 16,
  parameter int LAST_ADDR    = 47999,
  parameter int ROM_LATENCY  = 1,
  parameter int FILT_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_play,
  input  logic                  i_loop,
  input  logic                  i_rewind,
  input  logic                  i_filt_sel,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_q,
  output logic                  o_fir_wr,
  output logic [DATA_WIDTH-1:0] o_fir_din,
  input  logic [DATA_WIDTH-1:0] i_fir_dout,
  input  logic                  i_write_ready,
  output logic                  o_write,
  output logic [DATA_WIDTH-1:0] o_writedata_left,
  output logic [DATA_WIDTH-1:0] o_writedata_right,
  input  logic                  i_read_ready,
  output logic                  o_read,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_state
);

  // CODEC handshake: a sample is transferred on the single cycle o_write is
  // high; o_write only rises after a cycle in which i_write_ready was sampled 1.
  localparam int MAX_LAT = (ROM_LATENCY > FILT_LATENCY) ? ROM_LATENCY : FILT_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_FEED    = 3'd2,
    S_FWAIT   = 3'd3,
    S_WAIT_WR = 3'd4,
    S_WRITE   = 3'd5
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_armed;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_fir_din;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_fir_wr;
  logic                  r_write;
  logic                  r_done;
  logic                  r_read;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_armed    <= 1'b1;
      r_rom_addr <= '0;
      r_fir_din  <= '0;
      r_wdata    <= '0;
      r_fir_wr   <= 1'b0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_fir_wr <= 1'b0;
      r_write  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_play) r_armed <= 1'b1;
          if (i_rewind) r_rom_addr <= '0;
          if (i_play && r_armed) begin
            r_wait_cnt <= '0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_wait_cnt == CNT_W'(ROM_LATENCY - 1)) begin
            r_fir_din  <= i_rom_q;
            r_wait_cnt <= '0;
            r_fir_wr   <= 1'b1;
            r_state    <= S_FEED;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_FEED: r_state <= S_FWAIT;
        S_FWAIT: begin
          if (r_wait_cnt == CNT_W'(FILT_LATENCY - 1)) begin
            r_wdata    <= i_filt_sel ? i_fir_dout : r_fir_din;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT_WR;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_WAIT_WR: begin
          if (i_write_ready) begin
            r_write <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_rom_addr != ADDR_WIDTH'(LAST_ADDR)) begin
            r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
            r_state    <= i_play ? S_FETCH : S_IDLE;
          end else if (i_loop) begin
            r_rom_addr <= '0;
            r_state    <= i_play ? S_FETCH : S_IDLE;
          end else begin
            // End of one-shot playback: stay idle until play is re-pressed.
            r_rom_addr <= '0;
            r_done     <= 1'b1;
            r_armed    <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ADC drain runs on its own; the self-clearing toggle spaces pulses apart.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_read <= 1'b0;
    else         r_read <= i_read_ready & ~r_read;
  end

  assign o_rom_addr        = r_rom_addr;
  assign o_fir_wr          = r_fir_wr;
  assign o_fir_din         = r_fir_din;
  assign o_write           = r_write;
  assign o_writedata_left  = r_wdata;
  assign o_writedata_right = r_wdata;
  assign o_read            = r_read;
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;
  assign o_state           = r_state;

endmodule

// File: doc/audio_playback_ctrl.md
Name: audio_playback_ctrl

Overview:
Sequencer that streams samples from the sample ROM, through the FIR filter, into the audio CODEC write port. It generates the ROM addresses, the FIR write strobe and the CODEC write handshake, and selects filtered or unfiltered output. It replaces the free-running counter and the ready-tied read/write assigns in the audio top level. It also drains the CODEC ADC FIFO so the input path cannot overflow.

Parameters:
DATA_WIDTH, 24, sample width (ROM, FIR, CODEC).
ADDR_WIDTH, 16, ROM address width.
LAST_ADDR, 47999, final ROM address played; must be < 2^ADDR_WIDTH.
ROM_LATENCY, 1, cycles from rom_addr change to valid rom_q; must be >= 1.
FILT_LATENCY, 1, cycles from fir_wr to valid fir_dout; must be >= 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play  in  1  level; run while high
loop  in  1  1 = wrap to 0 after LAST_ADDR; 0 = stop after LAST_ADDR
rewind  in  1  in IDLE only, sets address to 0 on the next edge
filt_sel  in  1  1 = send FIR output to CODEC; 0 = send raw ROM sample
rom_addr  out  ADDR_WIDTH  registered ROM address
rom_q  in  DATA_WIDTH  ROM read data
fir_wr  out  1  one-cycle FIR shift strobe
fir_din  out  DATA_WIDTH  FIR input sample (registered)
fir_dout  in  DATA_WIDTH  FIR output
write_ready  in  1  CODEC DAC FIFO can accept a sample
write  out  1  one-cycle CODEC write strobe
writedata_left  out  DATA_WIDTH  left sample
writedata_right  out  DATA_WIDTH  right sample (always equals left)
read_ready  in  1  CODEC ADC FIFO non-empty
read  out  1  ADC drain strobe
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of non-looping playback

Behaviour:
- Reset (asynchronous) sets: state IDLE; rom_addr 0; fir_din 0; writedata_left and writedata_right 0; fir_wr, write, read, done 0; wait counter 0; armed 1.
- States: IDLE, FETCH, FEED, FWAIT, WAIT_WR, WRITE.
- IDLE:
  - play=1 and armed=1 -> FETCH.
  - rewind=1 -> rom_addr<=0. rewind is ignored outside IDLE.
  - play=0 -> armed<=1.
- FETCH: stay ROM_LATENCY cycles. On the final edge, capture fir_din<=rom_q, then -> FEED.
- FEED: fir_wr=1 for exactly this cycle, then -> FWAIT. The FIR is fed every sample regardless of filt_sel, so its history stays consistent.
- FWAIT: stay FILT_LATENCY cycles. On the final edge:
  - both writedata outputs <= (filt_sel ? fir_dout : fir_din); filt_sel is sampled only here;
  - -> WAIT_WR.
- WAIT_WR: hold. When write_ready=1 -> WRITE. writedata is stable from WAIT_WR entry through the end of WRITE.
- WRITE: write=1 for exactly this cycle. On exit:
  - rom_addr != LAST_ADDR: rom_addr+1; next state is FETCH if play=1, else IDLE.
  - rom_addr == LAST_ADDR and loop=1: rom_addr<=0; next state as above.
  - rom_addr == LAST_ADDR and loop=0: rom_addr<=0, done=1 next cycle, armed<=0, -> IDLE. Restart requires play to go low and then high again.
- Pause: play falling mid-sample does not abort. The current sample completes through WRITE, then IDLE with the incremented address retained.
- Throughput with both latencies 1 and write_ready held high: 5 cycles/sample (FETCH 1, FEED 1, FWAIT 1, WAIT_WR 1, WRITE 1).
- ADC drain is independent of the FSM: read is registered, read<=read_ready & ~read. This gives at most one pulse every other cycle while read_ready stays high.
- Simultaneous play rise and rewind in IDLE: rom_addr<=0 and -> FETCH on the same edge. FETCH then uses address 0.
- Reset mid-operation: immediate return to reset values; no partial write strobe may be emitted.
- No arithmetic beyond the address increment; address width is exact, with no overflow because the wrap occurs at LAST_ADDR.

Test Plan:
1. LAST_ADDR=3, latencies 1, loop=0, filt_sel=0, write_ready=1, ROM[i]=i+100, play raised once:
   - write pulses at 5-cycle spacing carry 100, 101, 102, 103;
   - done pulses once; busy then low; rom_addr=0;
   - holding play high produces no further writes until play cycles low then high.
2. Same setup with loop=1: after 103 the next write carries 100. Run 12 writes; the sequence repeats with no gap beyond 5 cycles.
3. filt_sel=1, fir_dout forced to 0xABCDEF:
   - each write carries 0xABCDEF on both channels;
   - fir_wr pulses once per sample, 1 cycle before FWAIT.
4. write_ready held low for 20 cycles in WAIT_WR:
   - write stays 0 and writedata is unchanged;
   - write pulses exactly 1 cycle after write_ready rises.
5. play dropped while in FEED at address 2: that sample's write still occurs; the FSM then idles with rom_addr=3. rewind=1 then sets rom_addr=0.
6. Asynchronous reset asserted during WAIT_WR: all outputs 0 without waiting for a clk edge. read_ready held high -> read toggles 1,0,1,0.
